// File: rtl/rv32im_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle, valid/ready handshakes, tag pass-through and flush.
module rv32im_muldiv_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_op,
  input  logic [WIDTH-1:0]     i_rs1_data,
  input  logic [WIDTH-1:0]     i_rs2_data,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_result,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 accept;
  logic                 a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 div_zero, div_ovf;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem, fin_result;

  assign o_ready  = !i_flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && i_ready));
  assign o_valid  = (state_q == S_DONE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_result = result_q;
  assign o_tag    = tag_q;
  assign accept   = i_valid && o_ready;

  always_comb begin
    // Operand conditioning for an incoming request
    a_signed = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
    b_signed = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
    a_neg    = a_signed && i_rs1_data[WIDTH-1];
    b_neg    = b_signed && i_rs2_data[WIDTH-1];
    a_mag    = a_neg ? -i_rs1_data : i_rs1_data;
    b_mag    = b_neg ? -i_rs2_data : i_rs2_data;
    div_zero = i_op[2] && (i_rs2_data == '0);
    div_ovf  = i_op[2] && !i_op[0] && (i_rs1_data == MIN_NEG) && (i_rs2_data == '1);

    // acc holds {hi, lo} of the product, or {remainder, quotient} when dividing
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opb_q} & {(WIDTH+1){acc_q[0]}});
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    if (op_q[2]) begin
      if (!div_diff[WIDTH]) step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod = neg_q ? -step_acc : step_acc;
    quo  = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    rem  = neg_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:          fin_result = prod[WIDTH-1:0];
      3'b001, 3'b010,
      3'b011:          fin_result = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:  fin_result = quo;
      default:         fin_result = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = fin_result;
        end
      end
      S_DONE: if (i_ready) state_d = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      op_d  = i_op;
      tag_d = i_tag;
      cnt_d = CW'(WIDTH - 1);
      case (i_op)
        3'b001, 3'b100: neg_d = a_neg ^ b_neg;
        3'b010, 3'b110: neg_d = a_neg;
        default:        neg_d = 1'b0;
      endcase
      if (i_op[2]) begin
        opb_d = b_mag;
        acc_d = {{WIDTH{1'b0}}, a_mag};
      end else begin
        opb_d = a_mag;
        acc_d = {{WIDTH{1'b0}}, b_mag};
      end
      if (div_zero) begin
        state_d  = S_DONE;
        result_d = i_op[1] ? i_rs1_data : '1;
      end else if (div_ovf) begin
        state_d  = S_DONE;
        result_d = i_op[1] ? '0 : i_rs1_data;
      end else begin
        state_d = S_CALC;
      end
    end

    if (i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_rv32im_muldiv_unit.sv
// Directed bench for rv32im_muldiv_unit: table of single ops plus handshake,
// flush and reset corner sequences.
module tb_rv32im_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = '0;
  logic [31:0] i_rs1_data = '0;
  logic [31:0] i_rs2_data = '0;
  logic [4:0]  i_tag = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  logic        o_busy;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  rv32im_muldiv_unit #(.WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_tag(i_tag),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_tag(o_tag), .o_busy(o_busy)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive a request at a negedge; returns once it has been clocked in.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    @(negedge clk);
    i_valid = 1'b1; i_op = op; i_rs1_data = a; i_rs2_data = b; i_tag = tag;
    #1 chk("ready_at_issue", {31'b0, o_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0; i_rs1_data = 32'hDEADBEEF; i_rs2_data = 32'h0BADF00D;
  endtask

  // Called at the first negedge after accept; counts cycles until o_valid.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] r_hold;
    logic [4:0]  t_hold;
    logic        seen;

    tbl[0]  = '{"MUL",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    tbl[1]  = '{"MULH",       3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    tbl[2]  = '{"MULHU",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    tbl[3]  = '{"MULHSU",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    tbl[4]  = '{"MULH_neg",   3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    tbl[5]  = '{"MULHU_mid",  3'b011, 32'h00010000, 32'h00030000, 32'h00000003, 33};
    tbl[6]  = '{"DIV",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    tbl[7]  = '{"REM",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    tbl[8]  = '{"DIVU",       3'b101, 32'd100,      32'd7,        32'd14,       33};
    tbl[9]  = '{"REMU",       3'b111, 32'd100,      32'd7,        32'd2,        33};
    tbl[10] = '{"DIV_negdiv", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    tbl[11] = '{"REM_negdiv", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    tbl[12] = '{"DIV_by0",    3'b100, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1};
    tbl[13] = '{"DIVU_by0",   3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1};
    tbl[14] = '{"REM_by0",    3'b110, 32'h00001234, 32'd0,        32'h00001234, 1};
    tbl[15] = '{"REMU_by0",   3'b111, 32'h00001234, 32'd0,        32'h00001234, 1};
    tbl[16] = '{"DIV_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[17] = '{"REM_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    // Reset state
    #12;
    chk("rst_valid",  {31'b0, o_valid}, 32'd0);
    chk("rst_busy",   {31'b0, o_busy},  32'd0);
    chk("rst_result", o_result,         32'd0);
    chk("rst_tag",    {27'b0, o_tag},   32'd0);
    chk("rst_ready",  {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1));
      wait_valid(cyc);
      chk({tbl[i].name, "_lat"}, cyc,                tbl[i].lat);
      chk({tbl[i].name, "_res"}, o_result,           tbl[i].exp);
      chk({tbl[i].name, "_tag"}, {27'b0, o_tag},     i + 1);
      drain();
      chk({tbl[i].name, "_drain"}, {31'b0, o_valid}, 32'd0);
    end

    // Backpressure: result held, then back-to-back accept on release
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    wait_valid(cyc);
    chk("bp_lat", cyc, 33);
    r_hold = o_result; t_hold = o_tag;
    chk("bp_res", r_hold, 32'd14);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_hold", {31'b0, o_valid}, 32'd1);
      chk("bp_res_hold",   o_result,         r_hold);
      chk("bp_tag_hold",   {27'b0, o_tag},   {27'b0, t_hold});
      chk("bp_ready_low",  {31'b0, o_ready}, 32'd0);
    end
    i_ready = 1'b1; i_valid = 1'b1; i_op = 3'b000; i_rs1_data = 32'd3; i_rs2_data = 32'd5; i_tag = 5'd4;
    #1 chk("b2b_ready", {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b0;
    chk("b2b_busy",  {31'b0, o_busy},  32'd1);
    chk("b2b_valid", {31'b0, o_valid}, 32'd0);
    wait_valid(cyc);
    chk("b2b_lat", cyc, 33);
    chk("b2b_res", o_result, 32'd15);
    chk("b2b_tag", {27'b0, o_tag}, 32'd4);
    drain();

    // Flush during CALC
    issue(3'b000, 32'd11, 32'd13, 5'd6);
    repeat (9) @(negedge clk);
    chk("fl_busy_before", {31'b0, o_busy}, 32'd1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("fl_busy", {31'b0, o_busy}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    chk("fl_no_valid", {31'b0, seen}, 32'd0);

    // Flush with i_valid in IDLE
    i_valid = 1'b1; i_flush = 1'b1; i_op = 3'b000; i_rs1_data = 32'd2; i_rs2_data = 32'd2;
    #1 chk("fl_idle_ready", {31'b0, o_ready}, 32'd0);
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    chk("fl_idle_busy", {31'b0, o_busy}, 32'd0);

    // Flush discards a DONE result even with i_ready
    issue(3'b101, 32'd5, 32'd0, 5'd7);
    chk("fl_done_valid", {31'b0, o_valid}, 32'd1);
    i_flush = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_flush = 1'b0; i_ready = 1'b0;
    chk("fl_done_gone", {31'b0, o_valid}, 32'd0);

    // Asynchronous reset mid-CALC
    issue(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd12);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid",  {31'b0, o_valid}, 32'd0);
    chk("arst_busy",   {31'b0, o_busy},  32'd0);
    chk("arst_result", o_result,         32'd0);
    chk("arst_tag",    {27'b0, o_tag},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("arst_ready", {31'b0, o_ready}, 32'd1);
    issue(3'b000, 32'd3, 32'd5, 5'd2);
    wait_valid(cyc);
    chk("post_rst_lat", cyc, 33);
    chk("post_rst_res", o_result, 32'd15);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32im_muldiv_unit.md
Name: rv32im_muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide execution unit for the RV32IM pipeline.
- Executes the full M-extension set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) alongside the single-cycle ALU in EX.
- Uses a valid/ready handshake on input and output, and carries a destination tag.
- A flush kills an in-flight operation.

Parameters:
- WIDTH, 32: operand/result width in bits; must be even and >= 8.
- TAG_WIDTH, 5: width of the pass-through tag (destination register index).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request this cycle.
- i_op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1_data  input  WIDTH  operand A (dividend or multiplicand).
- i_rs2_data  input  WIDTH  operand B (divisor or multiplier).
- i_tag  input  TAG_WIDTH  tag captured with the request.
- i_flush  input  1  kill any in-flight or pending operation.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_result  output  WIDTH  result.
- o_tag  output  TAG_WIDTH  tag of the request that produced o_result.
- o_busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - o_valid=0, o_result=0, o_tag=0, o_busy=0.
  - Counter and datapath registers cleared.
  - o_ready=1 once in IDLE.
- States: IDLE, CALC, DONE.
- o_ready = (state==IDLE) || (state==DONE && i_ready), and is 0 whenever i_flush=1.
- Accept: an edge with i_valid && o_ready.
  - Operands, op and tag are registered.
  - Signed ops take absolute values and record the result sign.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
- Normal path: accept leads to CALC with counter=WIDTH-1.
  - Multiply: one shift-add step per cycle into a 2*WIDTH product.
  - Divide: one restoring step per cycle (one quotient bit per cycle).
  - At the edge where counter==0, go to DONE.
  - o_valid rises WIDTH+1 cycles after the accept cycle (33 for WIDTH=32).
- Result selection and sign correction are applied on entry to DONE; o_result is registered.
  - MUL: low WIDTH bits of the product.
  - MULH, MULHSU, MULHU: high WIDTH bits of the product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient is negated if the operand signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Fast path: accept goes directly to DONE; o_valid is 1 in the next cycle.
  - Divisor == 0: quotient = all ones; remainder = dividend. Applies to signed and unsigned.
  - Signed overflow (DIV/REM with rs1 = most negative value and rs2 = -1): quotient = rs1; remainder = 0.
- DONE:
  - o_valid=1; o_result and o_tag are held stable until i_ready=1.
  - On i_ready=1 without a new accept: go to IDLE, o_valid=0.
  - On i_ready=1 with a same-cycle accept: the new operation starts with no bubble.
- Flush: i_flush=1 in any state sends the unit to IDLE on the next edge with o_valid=0.
  - An i_valid in the same cycle is ignored; flush wins.
  - A result in DONE is discarded even if i_ready=1.
- Inputs are don't-care while not being accepted. Changes to the input operands during CALC have no effect.
- Reset asserted during CALC or DONE: the operation is abandoned immediately and no o_valid pulse is produced.
- Arithmetic is modulo 2^WIDTH. No exceptions are raised.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, tag=3 -> o_valid 33 cycles after accept, o_result=0xFFFFFFEB, o_tag=3. Repeat with MULH 0x80000000*0x80000000 -> 0x40000000, MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2. Each result appears after 33 cycles.
- Division by zero: DIV and DIVU 0x00001234/0 -> 0xFFFFFFFF; REM -> 0x00001234. o_valid 1 cycle after accept. Overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid, o_result and o_tag stable and o_ready=0. Then i_ready=1 with a new i_valid in the same cycle -> next op accepted in that cycle.
- Flush at cycle 10 of CALC -> IDLE next cycle, o_valid never rises, o_busy=0. Flush together with i_valid in IDLE -> request not accepted.
- rst=0 asserted mid-CALC, asynchronously off a clock edge -> all outputs 0 immediately. After release -> o_ready=1, and a fresh MUL 3*5 -> 15.
